pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencer for the 5-stage MIPS core. It owns every stall, bubble and flush decision for the IF/ID and ID/EX registers: load-use interlock, taken-branch and jump squashes, and exception/interrupt entry and return. It also selects the next-PC source. It holds the supervisor state, EPC, cause and saturating hazard counters.

## Interface
- CNT_W, 16, width of the stall and flush event counters.
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low; clears all state.
- IDrs, IDrt  in  5 each  source registers of the instruction in ID.
- IDUsesRt  in  1  the ID instruction reads rt.
- IDPC  in  32  PC of the ID instruction; 0 marks a bubble.
- IDJump  in  1  j/jal/jr/jalr decoded in ID.
- IDEret  in  1  eret decoded in ID.
- illop, xadr  in  1 each  illegal-opcode / bad-address exception for the ID instruction.
- EXRegWriteAddr  in  5  destination register of the EX instruction.
- EXMemRead  in  1  the EX instruction is a load.
- EXBranchTaken  in  1  the branch in EX resolved taken.
- irq  in  1  level interrupt request.
- PCWrite  out  1  PC register enable.
- PCSel  out  3  0 = PC+4, 1 = branch target, 2 = jump target, 3 = 0x80000004 (irq), 4 = 0x80000008 (exception), 5 = EPC.
- IFIDStall  out  1  IF/ID holds its contents.
- IFIDFlush  out  1  IF/ID loads a bubble.
- IDEXFlush  out  1  ID/EX loads a bubble; drives its flush input.
- IrqAck  out  1  one-cycle pulse when an interrupt is taken.
- InKernel  out  1  supervisor state.
- EPC  out  32  exception return address.
- Cause  out  2  0 = none, 1 = irq, 2 = illop, 3 = xadr.
- StallCount, FlushCount  out  CNT_W each  event counters.

## Operation
- State machine with two states: RUN and KERNEL.
- irq_pend is set on any cycle with irq=1. It is cleared on the cycle the interrupt is taken.
- loaduse = EXMemRead and EXRegWriteAddr≠0 and (EXRegWriteAddr==IDrs or (IDUsesRt and EXRegWriteAddr==IDrt)).
- Per-cycle decision, highest priority first. Outputs not listed are default: PCWrite=1, PCSel=0, all others 0.
  1. EXBranchTaken: IFIDFlush=1, IDEXFlush=1, PCSel=1. A concurrent ID exception, eret or jump is ignored because that instruction is on the wrong path.
  2. illop or xadr: IFIDFlush=1, IDEXFlush=1, PCSel=4.
     - In RUN: EPC←IDPC; Cause←2 (illop) or 3 (xadr; illop wins if both); next state KERNEL.
     - In KERNEL: EPC and Cause are unchanged and the state stays KERNEL.
  3. irq_pend, state RUN, IDPC≠0, and not loaduse: IFIDFlush=1, IDEXFlush=1, PCSel=3, IrqAck=1; EPC←IDPC; Cause←1; clear irq_pend; next state KERNEL.
  4. loaduse: PCWrite=0, IFIDStall=1, IDEXFlush=1.
  5. IDEret in KERNEL: IFIDFlush=1, PCSel=5, Cause←0, next state RUN. IDEret in RUN is a no-op.
  6. IDJump: IFIDFlush=1, PCSel=2.
- StallCount increments on every cycle where step 4 fires. FlushCount increments on every cycle with IFIDFlush=1. Both saturate at all-ones.
- InKernel = (state==KERNEL).
- Interrupts are never taken in KERNEL. irq_pend stays set and is taken at the earliest in the cycle after eret has moved the state to RUN.

## Timing
- All control outputs (PCWrite, PCSel, IFIDStall, IFIDFlush, IDEXFlush, IrqAck) are combinational from current state, irq_pend and inputs, with no added latency.
- State, irq_pend, EPC, Cause and counters update on posedge clk.
- irq is sampled into irq_pend, so an interrupt is taken at the earliest one cycle after irq rises.
- Load-use costs exactly one bubble: the next cycle the load is in MEM, so loaduse=0.
- Reset (reset=0, asynchronous): state=RUN, irq_pend=0, EPC=0, Cause=0, StallCount=0, FlushCount=0.
  - During reset, outputs take default values evaluated with state RUN.
  - Reset asserted mid-sequence, including while in KERNEL, aborts to RUN with no pending interrupt.

## Test plan
- Load-use: lw $8 in EX (EXMemRead=1, EXRegWriteAddr=8), add using IDrs=8 in ID -> one cycle of PCWrite=0, IFIDStall=1, IDEXFlush=1; StallCount 0→1; normal flow the next cycle.
- Branch over exception: EXBranchTaken=1 and illop=1 in the same cycle -> PCSel=1, both flushes, EPC unchanged, state stays RUN, FlushCount+1.
- illop at IDPC=0x00400010 -> PCSel=4, EPC=0x00400010, Cause=2, InKernel=1. A following IDEret -> PCSel=5, InKernel=0, Cause=0.
- irq: pulse irq while in KERNEL -> no IrqAck. After eret, IDPC=0x00400020 -> IrqAck on the first RUN cycle, EPC=0x00400020, PCSel=3. An irq arriving while IDPC=0 waits for a non-zero IDPC.
- Saturation: CNT_W=4 with 20 load-use events -> StallCount holds at 0xF.
- Async reset asserted while in KERNEL with irq_pend=1 -> all registers zero immediately, InKernel=0, no IrqAck after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard/sequencing control for the 5-stage MIPS pipe. It owns the IF/ID and ID/EX
//          stall, bubble and flush decisions, next-PC select, supervisor state, EPC/Cause and
//          the stall/flush event counters.
// Latency: every control output is combinational from the current state and inputs. State and
//          counters update on posedge clk.
// Backpressure: a load-use hazard holds the PC and IF/ID for exactly one cycle and injects a
//          bubble into ID/EX.
// Ports:   ID-stage operands/decode (IDrs, IDrt, IDUsesRt, IDPC, IDJump, IDEret, illop, xadr),
//          EX-stage info (EXRegWriteAddr, EXMemRead, EXBranchTaken), and irq in.
//          Outputs: PCWrite/PCSel, IFIDStall/IFIDFlush/IDEXFlush, IrqAck, InKernel, EPC, Cause,
//          and StallCount/FlushCount.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IDrs,
  input  logic [4:0]       IDrt,
  input  logic             IDUsesRt,
  input  logic [31:0]      IDPC,
  input  logic             IDJump,
  input  logic             IDEret,
  input  logic             illop,
  input  logic             xadr,
  input  logic [4:0]       EXRegWriteAddr,
  input  logic             EXMemRead,
  input  logic             EXBranchTaken,
  input  logic             irq,
  output logic             PCWrite,
  output logic [2:0]       PCSel,
  output logic             IFIDStall,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             IrqAck,
  output logic             InKernel,
  output logic [31:0]      EPC,
  output logic [1:0]       Cause,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {S_RUN = 1'b0, S_KERNEL = 1'b1} state_t;

  localparam logic [2:0] SEL_PC4  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JMP  = 3'd2;
  localparam logic [2:0] SEL_IRQ  = 3'd3;
  localparam logic [2:0] SEL_EXC  = 3'd4;
  localparam logic [2:0] SEL_EPC  = 3'd5;

  state_t           r_state, w_next_state;
  logic             r_irq_pend;
  logic [31:0]      r_epc,   w_epc_next;
  logic [1:0]       r_cause, w_cause_next;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_loaduse;
  logic w_stall_evt;
  logic w_irq_take;

  // Register 0 is never a real producer, so a load to $0 cannot create a hazard.
  assign w_loaduse = EXMemRead && (EXRegWriteAddr != 5'd0) &&
                     ((EXRegWriteAddr == IDrs) || (IDUsesRt && (EXRegWriteAddr == IDrt)));

  always_comb begin
    PCWrite      = 1'b1;
    PCSel        = SEL_PC4;
    IFIDStall    = 1'b0;
    IFIDFlush    = 1'b0;
    IDEXFlush    = 1'b0;
    IrqAck       = 1'b0;
    w_stall_evt  = 1'b0;
    w_irq_take   = 1'b0;
    w_next_state = r_state;
    w_epc_next   = r_epc;
    w_cause_next = r_cause;

    if (EXBranchTaken) begin
      // Anything decoded in ID is on the wrong path and gets squashed silently.
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      PCSel     = SEL_BR;
    end else if (illop || xadr) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      PCSel     = SEL_EXC;
      // A nested exception inside the handler keeps the original EPC/Cause.
      if (r_state == S_RUN) begin
        w_epc_next   = IDPC;
        w_cause_next = illop ? 2'd2 : 2'd3;
        w_next_state = S_KERNEL;
      end
    end else if (r_irq_pend && (r_state == S_RUN) && (IDPC != 32'd0) && !w_loaduse) begin
      // A bubble in ID has no valid PC to return to, so wait for a real instruction.
      IFIDFlush    = 1'b1;
      IDEXFlush    = 1'b1;
      PCSel        = SEL_IRQ;
      IrqAck       = 1'b1;
      w_irq_take   = 1'b1;
      w_epc_next   = IDPC;
      w_cause_next = 2'd1;
      w_next_state = S_KERNEL;
    end else if (w_loaduse) begin
      PCWrite     = 1'b0;
      IFIDStall   = 1'b1;
      IDEXFlush   = 1'b1;
      w_stall_evt = 1'b1;
    end else if (IDEret && (r_state == S_KERNEL)) begin
      IFIDFlush    = 1'b1;
      PCSel        = SEL_EPC;
      w_cause_next = 2'd0;
      w_next_state = S_RUN;
    end else if (IDJump) begin
      IFIDFlush = 1'b1;
      PCSel     = SEL_JMP;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_irq_pend  <= 1'b0;
      r_epc       <= 32'd0;
      r_cause     <= 2'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      // Acknowledging the interrupt retires the request sampled so far.
      r_irq_pend <= w_irq_take ? 1'b0 : (r_irq_pend | irq);
      r_epc      <= w_epc_next;
      r_cause    <= w_cause_next;
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (IFIDFlush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign InKernel   = (r_state == S_KERNEL);
  assign EPC        = r_epc;
  assign Cause      = r_cause;
  assign StallCount = r_stall_cnt;
  assign FlushCount = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: self-checking bench for pipe_hazard_ctrl: directed scenarios followed by random
//          traffic, all compared against a behavioural model of the sequencing rules.
// Ports:   none; drives every DUT input and checks every DUT output at the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    IDrs, IDrt, EXRegWriteAddr;
  logic          IDUsesRt, IDJump, IDEret, illop, xadr, EXMemRead, EXBranchTaken, irq;
  logic [31:0]   IDPC;
  logic          PCWrite, IFIDStall, IFIDFlush, IDEXFlush, IrqAck, InKernel;
  logic [2:0]    PCSel;
  logic [31:0]   EPC;
  logic [1:0]    Cause;
  logic [CW-1:0] StallCount, FlushCount;

  pipe_hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .IDrs(IDrs), .IDrt(IDrt), .IDUsesRt(IDUsesRt), .IDPC(IDPC),
    .IDJump(IDJump), .IDEret(IDEret), .illop(illop), .xadr(xadr),
    .EXRegWriteAddr(EXRegWriteAddr), .EXMemRead(EXMemRead), .EXBranchTaken(EXBranchTaken),
    .irq(irq), .PCWrite(PCWrite), .PCSel(PCSel), .IFIDStall(IFIDStall), .IFIDFlush(IFIDFlush),
    .IDEXFlush(IDEXFlush), .IrqAck(IrqAck), .InKernel(InKernel), .EPC(EPC), .Cause(Cause),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // Reference model: architectural state held as plain values.
  bit        m_kernel, m_pend;
  int        m_epc, m_cause, m_stall, m_flush;
  // Expected combinational outputs for the current cycle.
  bit        e_pcw, e_stall, e_iff, e_idf, e_ack;
  int        e_sel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_kernel = 0; m_pend = 0; m_epc = 0; m_cause = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic idle();
    IDrs = 0; IDrt = 0; IDUsesRt = 0; IDPC = 32'h0040_0000; IDJump = 0; IDEret = 0;
    illop = 0; xadr = 0; EXRegWriteAddr = 0; EXMemRead = 0; EXBranchTaken = 0; irq = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".PCWrite"},    32'(PCWrite),    32'(e_pcw));
    chk({tag, ".PCSel"},      32'(PCSel),      32'(e_sel));
    chk({tag, ".IFIDStall"},  32'(IFIDStall),  32'(e_stall));
    chk({tag, ".IFIDFlush"},  32'(IFIDFlush),  32'(e_iff));
    chk({tag, ".IDEXFlush"},  32'(IDEXFlush),  32'(e_idf));
    chk({tag, ".IrqAck"},     32'(IrqAck),     32'(e_ack));
    chk({tag, ".InKernel"},   32'(InKernel),   32'(m_kernel));
    chk({tag, ".EPC"},        EPC,             32'(m_epc));
    chk({tag, ".Cause"},      32'(Cause),      32'(m_cause));
    chk({tag, ".StallCount"}, 32'(StallCount), 32'(m_stall));
    chk({tag, ".FlushCount"}, 32'(FlushCount), 32'(m_flush));
  endtask

  // One clock: inputs are already applied (just after a rising edge). The model decides the
  // cycle, outputs are checked at the falling edge, then the model commits after the edge.
  task automatic step(input string tag);
    bit lu, br, exc, take, n_kernel, n_pend;
    int n_epc, n_cause;
    lu   = EXMemRead && EXRegWriteAddr != 0 &&
           (EXRegWriteAddr == IDrs || (IDUsesRt && EXRegWriteAddr == IDrt));
    br   = EXBranchTaken;
    exc  = illop || xadr;
    take = !br && !exc && m_pend && !m_kernel && IDPC != 0 && !lu;
    // Keep the request low on the acknowledge cycle so a fresh request never coincides.
    if (take) irq = 0;
    e_pcw = 1; e_sel = 0; e_stall = 0; e_iff = 0; e_idf = 0; e_ack = 0;
    n_kernel = m_kernel; n_epc = m_epc; n_cause = m_cause;
    n_pend = take ? 1'b0 : (m_pend | irq);
    if (br) begin
      e_iff = 1; e_idf = 1; e_sel = 1;
    end else if (exc) begin
      e_iff = 1; e_idf = 1; e_sel = 4;
      if (!m_kernel) begin
        n_epc = IDPC; n_cause = illop ? 2 : 3; n_kernel = 1;
      end
    end else if (take) begin
      e_iff = 1; e_idf = 1; e_sel = 3; e_ack = 1;
      n_epc = IDPC; n_cause = 1; n_kernel = 1;
    end else if (lu) begin
      e_pcw = 0; e_stall = 1; e_idf = 1;
    end else if (IDEret && m_kernel) begin
      e_iff = 1; e_sel = 5; n_cause = 0; n_kernel = 0;
    end else if (IDJump) begin
      e_iff = 1; e_sel = 2;
    end
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    #1;
    m_kernel = n_kernel; m_pend = n_pend; m_epc = n_epc; m_cause = n_cause;
    if (e_stall && m_stall < CMAX) m_stall++;
    if (e_iff && m_flush < CMAX) m_flush++;
  endtask

  initial begin
    idle();
    model_reset();
    e_pcw = 1; e_sel = 0; e_stall = 0; e_iff = 0; e_idf = 0; e_ack = 0;

    // Reset: registers cleared, outputs at their RUN defaults.
    reset = 0;
    irq   = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    irq = 0;
    reset = 1;
    @(posedge clk);
    #1;

    // Load-use: one bubble, then normal flow.
    EXMemRead = 1; EXRegWriteAddr = 8; IDrs = 8; IDPC = 32'h0040_0004;
    step("loaduse");
    idle();
    step("loaduse_next");
    chk("loaduse_stallcnt", 32'(StallCount), 32'd1);

    // Taken branch hides a concurrent illegal opcode.
    EXBranchTaken = 1; illop = 1; IDPC = 32'h0040_0008;
    step("br_over_exc");
    idle();
    chk("br_over_exc_kernel", 32'(InKernel), 32'd0);
    step("br_over_exc_next");

    // Illegal opcode enters the handler, eret returns.
    illop = 1; IDPC = 32'h0040_0010;
    step("illop");
    idle();
    chk("illop_epc", EPC, 32'h0040_0010);
    chk("illop_cause", 32'(Cause), 32'd2);
    IDEret = 1;
    step("eret");
    idle();
    chk("eret_kernel", 32'(InKernel), 32'd0);

    // Interrupt raised in the handler waits until eret has restored RUN.
    xadr = 1; IDPC = 32'h0040_0014;
    step("xadr");
    idle();
    irq = 1;
    step("irq_in_kernel");
    idle();
    IDEret = 1;
    step("eret_pending");
    idle();
    IDPC = 32'h0040_0020;
    step("irq_take");
    chk("irq_take_epc", EPC, 32'h0040_0020);
    chk("irq_take_cause", 32'(Cause), 32'd1);
    IDEret = 1;
    step("irq_ret");
    idle();

    // Request with a bubble in ID waits for a real instruction.
    IDPC = 0; irq = 1;
    step("irq_bubble0");
    irq = 0;
    step("irq_bubble1");
    IDPC = 32'h0040_0030;
    step("irq_bubble_take");
    idle();
    IDEret = 1;
    step("irq_bubble_ret");
    idle();

    // Counter saturation: 20 load-use cycles.
    for (int i = 0; i < 20; i++) begin
      EXMemRead = 1; EXRegWriteAddr = 5'd9; IDUsesRt = 1; IDrt = 5'd9; IDrs = 5'd3;
      step("sat");
    end
    idle();
    chk("sat_stallcnt", 32'(StallCount), 32'(CMAX));

    // Asynchronous reset while in the handler with an interrupt pending.
    illop = 1; IDPC = 32'h0040_0040;
    step("pre_rst_exc");
    idle();
    irq = 1;
    step("pre_rst_irq");
    irq = 0;
    #2;
    reset = 0;
    #1;
    model_reset();
    chk("arst_kernel", 32'(InKernel), 32'd0);
    chk("arst_epc", EPC, 32'd0);
    chk("arst_cause", 32'(Cause), 32'd0);
    chk("arst_stall", 32'(StallCount), 32'd0);
    chk("arst_flush", 32'(FlushCount), 32'd0);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    IDPC = 32'h0040_0050;
    step("post_rst");
    chk("post_rst_noack", 32'(IrqAck), 32'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      IDrs           = 5'($urandom_range(0, 3));
      IDrt           = 5'($urandom_range(0, 3));
      IDUsesRt       = 1'($urandom_range(0, 1));
      EXRegWriteAddr = 5'($urandom_range(0, 3));
      EXMemRead      = ($urandom_range(0, 3) == 0);
      IDPC           = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFC);
      IDJump         = ($urandom_range(0, 5) == 0);
      IDEret         = ($urandom_range(0, 4) == 0);
      illop          = ($urandom_range(0, 15) == 0);
      xadr           = ($urandom_range(0, 15) == 0);
      EXBranchTaken  = ($urandom_range(0, 7) == 0);
      irq            = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
